// File: rtl/ascon_ad_absorb.sv
// rtl/ascon_ad_absorb.sv - ASCON-128 associated-data absorption stage (p6 per AD block, domain separation)
// Optional build macro ASCON_AD_UNROLL2_EN: two permutation rounds per cycle (ROUNDS_B must be even).
module ascon_ad_absorb #(
    parameter int ROUNDS_B = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [63:0] x0,
    input  logic [63:0] x1,
    input  logic [63:0] x2,
    input  logic [63:0] x3,
    input  logic [63:0] x4,
    input  logic        no_ad,
    input  logic        ad_valid,
    output logic        ad_ready,
    input  logic [63:0] ad_data,
    input  logic [3:0]  ad_bytes,
    input  logic        ad_last,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] y0,
    output logic [63:0] y1,
    output logic [63:0] y2,
    output logic [63:0] y3,
    output logic [63:0] y4
);

    typedef enum logic [1:0] {IDLE, ABSORB, PERM, DONE} state_t;

    localparam logic [3:0]  RND_FIRST = 4'(12 - ROUNDS_B);
    localparam logic [63:0] PAD_MSB   = 64'h8000_0000_0000_0000;

    state_t      state;
    logic [63:0] s0, s1, s2, s3, s4;
    logic [3:0]  rnd;
    logic        pad_pend;
    logic        last_blk;

    logic [3:0]   nb_eff;
    logic [63:0]  keep_mask;
    logic [63:0]  pad_byte;
    logic [63:0]  ad_block;
    logic [319:0] perm_in;
    logic [319:0] perm_out;
    logic [3:0]   rnd_step;
    logic         rnd_final;

    function automatic logic [63:0] ror64(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    // One ASCON round: constant addition, bit-sliced 5-bit S-box, linear diffusion.
    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] a0, a1, a2, a3, a4;
        logic [63:0] t0, t1, t2, t3, t4;
        {a0, a1, a2, a3, a4} = s;
        a2 = a2 ^ {56'h0, 4'(4'hF - r), r};
        a0 = a0 ^ a4;
        a4 = a4 ^ a3;
        a2 = a2 ^ a1;
        t0 = ~a0 & a1;
        t1 = ~a1 & a2;
        t2 = ~a2 & a3;
        t3 = ~a3 & a4;
        t4 = ~a4 & a0;
        a0 = a0 ^ t1;
        a1 = a1 ^ t2;
        a2 = a2 ^ t3;
        a3 = a3 ^ t4;
        a4 = a4 ^ t0;
        a1 = a1 ^ a0;
        a0 = a0 ^ a4;
        a3 = a3 ^ a2;
        a2 = ~a2;
        a0 = a0 ^ ror64(a0, 19) ^ ror64(a0, 28);
        a1 = a1 ^ ror64(a1, 61) ^ ror64(a1, 39);
        a2 = a2 ^ ror64(a2, 1)  ^ ror64(a2, 6);
        a3 = a3 ^ ror64(a3, 10) ^ ror64(a3, 17);
        a4 = a4 ^ ror64(a4, 7)  ^ ror64(a4, 41);
        return {a0, a1, a2, a3, a4};
    endfunction

    // A partial block keeps its top n bytes and gets 0x80 right after them.
    always_comb begin
        nb_eff    = (ad_bytes == 4'd0 || ad_bytes > 4'd8) ? 4'd8 : ad_bytes;
        keep_mask = ~(64'hFFFF_FFFF_FFFF_FFFF >> {nb_eff, 3'b000});
        pad_byte  = (nb_eff == 4'd8) ? 64'h0 : (64'h80 << (7'd56 - {nb_eff, 3'b000}));
        ad_block  = (ad_data & keep_mask) | pad_byte;
    end

    assign perm_in = {s0, s1, s2, s3, s4};

`ifdef ASCON_AD_UNROLL2_EN
    assign perm_out  = ascon_round(ascon_round(perm_in, rnd), rnd + 4'd1);
    assign rnd_step  = 4'd2;
    assign rnd_final = (rnd == 4'd10);
`else
    assign perm_out  = ascon_round(perm_in, rnd);
    assign rnd_step  = 4'd1;
    assign rnd_final = (rnd == 4'd11);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s0       <= 64'h0;
            s1       <= 64'h0;
            s2       <= 64'h0;
            s3       <= 64'h0;
            s4       <= 64'h0;
            rnd      <= 4'h0;
            pad_pend <= 1'b0;
            last_blk <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        s0 <= x0;
                        s1 <= x1;
                        s2 <= x2;
                        s3 <= x3;
                        if (no_ad) begin
                            s4    <= x4 ^ 64'h1;
                            state <= DONE;
                        end else begin
                            s4    <= x4;
                            state <= ABSORB;
                        end
                    end
                end
                ABSORB: begin
                    if (ad_valid) begin
                        s0       <= s0 ^ ad_block;
                        rnd      <= RND_FIRST;
                        last_blk <= ad_last;
                        pad_pend <= ad_last && (nb_eff == 4'd8);
                        state    <= PERM;
                    end
                end
                PERM: begin
                    {s0, s1, s2, s3, s4} <= perm_out;
                    rnd <= rnd + rnd_step;
                    if (rnd_final) begin
                        // A full final block still owes the lone 0x80 pad block.
                        if (pad_pend) begin
                            s0       <= perm_out[319:256] ^ PAD_MSB;
                            pad_pend <= 1'b0;
                            rnd      <= RND_FIRST;
                        end else if (last_blk) begin
                            s4    <= perm_out[63:0] ^ 64'h1;
                            state <= DONE;
                        end else begin
                            state <= ABSORB;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign s_ready   = (state == IDLE);
    assign ad_ready  = (state == ABSORB);
    assign out_valid = (state == DONE);
    assign y0 = s0;
    assign y1 = s1;
    assign y2 = s2;
    assign y3 = s3;
    assign y4 = s4;

endmodule

// File: tb/tb_ascon_ad_absorb.sv
// tb/tb_ascon_ad_absorb.sv - randomized self-checking bench for ascon_ad_absorb against a byte-level ASCON AD model
module tb_ascon_ad_absorb;

    localparam int ROUNDS_B = 6;
`ifdef ASCON_AD_UNROLL2_EN
    localparam int LAT = ROUNDS_B / 2;
`else
    localparam int LAT = ROUNDS_B;
`endif

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid, s_ready, no_ad;
    logic [63:0] x0, x1, x2, x3, x4;
    logic        ad_valid, ad_ready, ad_last;
    logic [63:0] ad_data;
    logic [3:0]  ad_bytes;
    logic        out_valid, out_ready;
    logic [63:0] y0, y1, y2, y3, y4;

    int n_checks = 0;
    int n_fails  = 0;

    byte unsigned adq [$];
    logic [63:0]  xs [5];
    logic [63:0]  m  [5];

    ascon_ad_absorb #(.ROUNDS_B(ROUNDS_B)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready),
        .x0(x0), .x1(x1), .x2(x2), .x3(x3), .x4(x4), .no_ad(no_ad),
        .ad_valid(ad_valid), .ad_ready(ad_ready), .ad_data(ad_data),
        .ad_bytes(ad_bytes), .ad_last(ad_last),
        .out_valid(out_valid), .out_ready(out_ready),
        .y0(y0), .y1(y1), .y2(y2), .y3(y3), .y4(y4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] rot(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Reference permutation: table S-box applied column by column.
    task automatic model_perm(input int nr);
        logic [4:0] v;
        for (int r = 12 - nr; r < 12; r++) begin
            m[2] = m[2] ^ 64'((15 - r) * 16 + r);
            for (int i = 0; i < 64; i++) begin
                v = {m[0][i], m[1][i], m[2][i], m[3][i], m[4][i]};
                {m[0][i], m[1][i], m[2][i], m[3][i], m[4][i]} = SBOX[v];
            end
            m[0] = m[0] ^ rot(m[0], 19) ^ rot(m[0], 28);
            m[1] = m[1] ^ rot(m[1], 61) ^ rot(m[1], 39);
            m[2] = m[2] ^ rot(m[2], 1)  ^ rot(m[2], 6);
            m[3] = m[3] ^ rot(m[3], 10) ^ rot(m[3], 17);
            m[4] = m[4] ^ rot(m[4], 7)  ^ rot(m[4], 41);
        end
    endtask

    // ASCON AD phase: append 0x80, zero-fill to 8-byte multiple, absorb, then domain separate.
    task automatic model_absorb();
        byte unsigned p [$];
        logic [63:0] blk;
        for (int i = 0; i < 5; i++) m[i] = xs[i];
        if (adq.size() > 0) begin
            p = adq;
            p.push_back(8'h80);
            while (p.size() % 8 != 0) p.push_back(8'h00);
            for (int b = 0; b < p.size() / 8; b++) begin
                blk = 64'h0;
                for (int j = 0; j < 8; j++) blk = (blk << 8) | 64'(p[8 * b + j]);
                m[0] = m[0] ^ blk;
                model_perm(ROUNDS_B);
            end
        end
        m[4] = m[4] ^ 64'h1;
    endtask

    task automatic check_y(input string tag);
        check({tag, "_y0"}, y0, m[0]);
        check({tag, "_y1"}, y1, m[1]);
        check({tag, "_y2"}, y2, m[2]);
        check({tag, "_y3"}, y3, m[3]);
        check({tag, "_y4"}, y4, m[4]);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, 64'(s_ready), 64'h1);
        check({tag, "_ad_ready"}, 64'(ad_ready), 64'h0);
        check({tag, "_out_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_y"}, y0 | y1 | y2 | y3 | y4, 64'h0);
    endtask

    task automatic present_state(input bit zero_state);
        int c;
        for (int i = 0; i < 5; i++) xs[i] = zero_state ? 64'h0 : rnd64();
        {x0, x1, x2, x3, x4} = {xs[0], xs[1], xs[2], xs[3], xs[4]};
        no_ad   = (adq.size() == 0);
        s_valid = 1'b1;
        c = 0;
        while (!s_ready && c < 50) begin @(posedge clk); #1; c++; end
        check("s_ready_wait", 64'(s_ready), 64'h1);
        @(posedge clk); #1;
        s_valid = 1'b0;
        {x0, x1, x2, x3, x4} = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
        no_ad = 1'($urandom);
    endtask

    task automatic run_txn(input int bp_cycles, input bit zero_state, input string tag);
        int len, nblk, nb, c, lat, exp_lat;
        logic [63:0] d;
        bit last;
        len = adq.size();
        for (int i = 0; i < 5; i++) xs[i] = zero_state ? 64'h0 : rnd64();
        present_state(zero_state);
        model_absorb();
        if (len == 0) check({tag, "_noad_out_valid"}, 64'(out_valid), 64'h1);
        else          check({tag, "_ad_ready_after_s"}, 64'(ad_ready), 64'h1);
        nblk = (len + 7) / 8;
        for (int k = 0; k < nblk; k++) begin
            nb   = (len - 8 * k >= 8) ? 8 : len - 8 * k;
            last = (k == nblk - 1);
            d    = rnd64();
            for (int j = 0; j < nb; j++) d[63 - 8 * j -: 8] = adq[8 * k + j];
            ad_data  = d;
            ad_bytes = (nb == 8) ? (($urandom % 2) ? 4'd0 : 4'd8) : 4'(nb);
            ad_last  = last;
            ad_valid = 1'b1;
            c = 0;
            while (!ad_ready && c < 50) begin @(posedge clk); #1; c++; end
            check({tag, "_ad_ready_wait"}, 64'(ad_ready), 64'h1);
            @(posedge clk); #1;
            exp_lat = (last && nb == 8) ? 2 * LAT : LAT;
            lat = 0;
            while (!ad_ready && !out_valid && lat < 100) begin
                ad_valid = 1'($urandom);
                ad_data  = rnd64();
                ad_last  = 1'($urandom);
                ad_bytes = 4'($urandom);
                @(posedge clk); #1;
                lat++;
            end
            ad_valid = 1'b0;
            check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
            check({tag, "_done_on_last"}, 64'(out_valid), 64'(last));
        end
        check_y(tag);
        s_valid = 1'b1;
        {x0, x1, x2, x3, x4} = {rnd64(), rnd64(), rnd64(), rnd64(), rnd64()};
        for (int b = 0; b < bp_cycles; b++) begin
            @(posedge clk); #1;
            check({tag, "_bp_out_valid"}, 64'(out_valid), 64'h1);
            check({tag, "_bp_s_ready"}, 64'(s_ready), 64'h0);
            check_y({tag, "_bp"});
        end
        s_valid   = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_post_out_valid"}, 64'(out_valid), 64'h0);
        check({tag, "_post_s_ready"}, 64'(s_ready), 64'h1);
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        s_valid = 1'b0; no_ad = 1'b0; out_ready = 1'b0;
        ad_valid = 1'b0; ad_last = 1'b0; ad_bytes = 4'd0; ad_data = 64'h0;
        {x0, x1, x2, x3, x4} = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_held");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("reset_released");

        adq.delete();
        run_txn(0, 1'b1, "noad_zero");

        adq = '{8'h61, 8'h62, 8'h63};
        run_txn(2, 1'b0, "abc");

        adq.delete();
        for (int i = 0; i < 8; i++) adq.push_back(8'($urandom));
        run_txn(0, 1'b0, "full8");

        adq.delete();
        for (int i = 0; i < 21; i++) adq.push_back(8'($urandom));
        run_txn(10, 1'b0, "three_blk");

        // Abort a permutation with reset, then confirm normal restart.
        adq.delete();
        adq.push_back(8'h11);
        present_state(1'b0);
        ad_data = rnd64(); ad_bytes = 4'd8; ad_last = 1'b0; ad_valid = 1'b1;
        c = 0;
        while (!ad_ready && c < 50) begin @(posedge clk); #1; c++; end
        check("midperm_ad_ready_wait", 64'(ad_ready), 64'h1);
        @(posedge clk); #1;
        ad_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("midperm_busy", 64'(ad_ready | out_valid | s_ready), 64'h0);
        rst_n = 1'b0;
        #2;
        check_reset_outputs("midperm_reset");
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        adq.delete();
        for (int i = 0; i < 13; i++) adq.push_back(8'($urandom));
        run_txn(1, 1'b0, "after_reset");

        for (int t = 0; t < 25; t++) begin
            int len;
            adq.delete();
            len = $urandom_range(0, 40);
            for (int i = 0; i < len; i++) adq.push_back(8'($urandom));
            run_txn($urandom_range(0, 4), 1'b0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
